pakin_arb: RTL and testbench

//  Two-input packet-link arbiter in front of pakin. Merges two 4-phase req/ack

---
 rtl/pakin_arb.sv | 120 ++++++++++++
 tb/tb_pakin_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pakin_arb.sv
// Two-source 4-phase packet-link arbiter in front of pakin. The grant is held for
// a whole message of TOT_PKS packets, and sources alternate at message boundaries.
module pakin_arb #(
    parameter int PSZ     = 8,
    parameter int TOT_PKS = 3,
    parameter int CSZ     = $clog2(TOT_PKS + 1)
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [PSZ-1:0] rcv0_data,
    input  logic           rcv1_req,
    output logic           rcv1_ack,
    input  logic [PSZ-1:0] rcv1_data,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [PSZ-1:0] snd0_data
);

    typedef enum logic [2:0] {IDLE, SND, SNDW, SRCW, NEXT} state_t;

    localparam logic [CSZ-1:0] LAST_PK = CSZ'(TOT_PKS - 1);

    state_t         state, state_n;
    logic [CSZ-1:0] cnt, cnt_n;
    logic           owner, owner_n;
    logic           last, last_n;
    logic           snd0_req_n, rcv0_ack_n, rcv1_ack_n;
    logic [PSZ-1:0] snd0_data_n;
    logic           own_req;
    logic           pick;

    assign own_req = owner ? rcv1_req : rcv0_req;
    // With both sources requesting, the one that did not own the previous message wins.
    assign pick    = (rcv0_req && rcv1_req) ? ~last : rcv1_req;

    always_ff @(posedge gch_clk) begin
        if (!gch_reset) begin
            gch_ready <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            snd0_req  <= 1'b0;
            rcv0_ack  <= 1'b0;
            rcv1_ack  <= 1'b0;
            snd0_data <= '0;
        end else begin
            gch_ready <= 1'b1;
            state     <= state_n;
            cnt       <= cnt_n;
            owner     <= owner_n;
            last      <= last_n;
            snd0_req  <= snd0_req_n;
            rcv0_ack  <= rcv0_ack_n;
            rcv1_ack  <= rcv1_ack_n;
            snd0_data <= snd0_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        owner_n     = owner;
        last_n      = last;
        snd0_req_n  = snd0_req;
        rcv0_ack_n  = rcv0_ack;
        rcv1_ack_n  = rcv1_ack;
        snd0_data_n = snd0_data;
        unique case (state)
            IDLE: begin
                if (gch_ready && (rcv0_req || rcv1_req)) begin
                    owner_n     = pick;
                    snd0_data_n = pick ? rcv1_data : rcv0_data;
                    snd0_req_n  = 1'b1;
                    state_n     = SND;
                end
            end
            SND: begin
                if (snd0_ack) begin
                    snd0_req_n = 1'b0;
                    state_n    = SNDW;
                end
            end
            // The source is only released once pakin has finished its own handshake.
            SNDW: begin
                if (!snd0_ack) begin
                    if (owner) rcv1_ack_n = 1'b1;
                    else       rcv0_ack_n = 1'b1;
                    state_n = SRCW;
                end
            end
            SRCW: begin
                if (!own_req) begin
                    rcv0_ack_n = 1'b0;
                    rcv1_ack_n = 1'b0;
                    if (cnt == LAST_PK) begin
                        cnt_n   = '0;
                        last_n  = owner;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = cnt + CSZ'(1);
                        state_n = NEXT;
                    end
                end
            end
            NEXT: begin
                if (own_req) begin
                    snd0_data_n = owner ? rcv1_data : rcv0_data;
                    snd0_req_n  = 1'b1;
                    state_n     = SND;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pakin_arb.sv
// Self-checking bench for pakin_arb: cycle-exact vector table, then behavioural
// sources and sink for back-pressure, reset-abort and randomized round-robin runs.
module tb_pakin_arb;

    localparam int PSZ     = 8;
    localparam int TOT_PKS = 3;

    logic           gch_clk = 1'b0;
    logic           gch_reset = 1'b0;
    logic           gch_ready;
    logic           rcv0_req, rcv0_ack, rcv1_req, rcv1_ack;
    logic [PSZ-1:0] rcv0_data, rcv1_data, snd0_data;
    logic           snd0_req, snd0_ack;

    int total = 0;
    int bad   = 0;

    // Table mode drives links directly; otherwise behavioural source/sink threads do.
    logic           tab_mode = 1'b1;
    logic           tab_r0req = 1'b0, tab_r1req = 1'b0, tab_ack = 1'b0;
    logic [PSZ-1:0] tab_d0 = '0, tab_d1 = '0;
    logic           src_req[2];
    logic [PSZ-1:0] src_data[2];
    logic           src_busy[2];
    logic           sink_ack = 1'b0;
    logic           sink_en = 1'b0, sink_stall = 1'b0;
    int             sink_dly_max = 0;
    int             src_gap_max = 0;
    logic [PSZ-1:0] q0[$], q1[$], rx_q[$], exp_q[$];
    logic           mon_en = 1'b0;
    int             mon_viol = 0;

    assign rcv0_req  = tab_mode ? tab_r0req : src_req[0];
    assign rcv1_req  = tab_mode ? tab_r1req : src_req[1];
    assign rcv0_data = tab_mode ? tab_d0 : src_data[0];
    assign rcv1_data = tab_mode ? tab_d1 : src_data[1];
    assign snd0_ack  = tab_mode ? tab_ack : sink_ack;

    pakin_arb #(.PSZ(PSZ), .TOT_PKS(TOT_PKS)) dut (
        .gch_clk   (gch_clk),
        .gch_reset (gch_reset),
        .gch_ready (gch_ready),
        .rcv0_req  (rcv0_req),
        .rcv0_ack  (rcv0_ack),
        .rcv0_data (rcv0_data),
        .rcv1_req  (rcv1_req),
        .rcv1_ack  (rcv1_ack),
        .rcv1_data (rcv1_data),
        .snd0_req  (snd0_req),
        .snd0_ack  (snd0_ack),
        .snd0_data (snd0_data)
    );

    always #5 gch_clk = ~gch_clk;

    typedef struct {
        logic           rst;
        logic           r0req;
        logic [PSZ-1:0] d0;
        logic           r1req;
        logic [PSZ-1:0] d1;
        logic           sack;
        logic [11:0]    exp_out;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic rst, input logic r0, input logic [7:0] d0,
                                   input logic r1, input logic [7:0] d1, input logic sack,
                                   input logic rdy, input logic sreq, input logic a0,
                                   input logic a1, input logic [7:0] sd);
        vec_t v;
        v.rst = rst; v.r0req = r0; v.d0 = d0; v.r1req = r1; v.d1 = d1; v.sack = sack;
        v.exp_out = {rdy, sreq, a0, a1, sd};
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] outVec();
        return {gch_ready, snd0_req, rcv0_ack, rcv1_ack, snd0_data};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        gch_reset = v.rst;
        tab_r0req = v.r0req;
        tab_d0    = v.d0;
        tab_r1req = v.r1req;
        tab_d1    = v.d1;
        tab_ack   = v.sack;
    endtask

    task automatic waitAck(input int k, input logic val);
        int n = 0;
        while (((k == 0) ? rcv0_ack : rcv1_ack) !== val && n < 500) begin
            @(negedge gch_clk);
            n++;
        end
        if (n >= 500)
            checkOutput($sformatf("src%0d_ack_timeout", k), 32'((k == 0) ? rcv0_ack : rcv1_ack), 32'(val));
    endtask

    // Behavioural 4-phase source: sends everything queued for it, one packet at a time.
    task automatic runSource(input int k);
        forever begin
            @(negedge gch_clk);
            if (((k == 0) ? q0.size() : q1.size()) > 0) begin
                src_busy[k] = 1'b1;
                src_data[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
                src_req[k]  = 1'b1;
                waitAck(k, 1'b1);
                src_req[k]  = 1'b0;
                waitAck(k, 1'b0);
                repeat ($urandom_range(src_gap_max, 0)) @(negedge gch_clk);
                src_busy[k] = 1'b0;
            end
        end
    endtask

    initial begin
        src_req[0] = 1'b0; src_req[1] = 1'b0;
        src_data[0] = '0;  src_data[1] = '0;
        src_busy[0] = 1'b0; src_busy[1] = 1'b0;
    end

    initial runSource(0);
    initial runSource(1);

    // Behavioural pakin: records each packet and completes the 4-phase handshake.
    initial begin
        forever begin
            @(negedge gch_clk);
            if (sink_en && snd0_req && !sink_ack && !sink_stall) begin
                repeat ($urandom_range(sink_dly_max, 0)) @(negedge gch_clk);
                rx_q.push_back(snd0_data);
                sink_ack = 1'b1;
                for (int i = 0; i < 200 && snd0_req; i++) @(negedge gch_clk);
                repeat ($urandom_range(sink_dly_max, 0)) @(negedge gch_clk);
                sink_ack = 1'b0;
            end
        end
    end

    // Protocol watch: never two acks at once; output data frozen while its request is up.
    initial begin
        logic           prev_req = 1'b0;
        logic [PSZ-1:0] prev_data = '0;
        forever begin
            @(negedge gch_clk);
            if (mon_en && gch_reset) begin
                if (rcv0_ack && rcv1_ack) mon_viol++;
                if (prev_req && snd0_req && snd0_data !== prev_data) mon_viol++;
            end
            prev_req  = snd0_req;
            prev_data = snd0_data;
        end
    end

    task automatic doReset(input int n);
        @(negedge gch_clk);
        gch_reset = 1'b0;
        repeat (n) @(negedge gch_clk);
        checkOutput("reset_outputs", 32'(outVec()), 32'd0);
        gch_reset = 1'b1;
    endtask

    task automatic waitRx(input int n, input int budget, input string name);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge gch_clk);
            c++;
        end
        checkOutput(name, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic waitSrcIdle(input int k);
        int c = 0;
        while (src_busy[k] && c < 500) begin
            @(negedge gch_clk);
            c++;
        end
        checkOutput($sformatf("src%0d_idle", k), 32'(src_busy[k]), 32'd0);
    endtask

    initial begin
        logic [PSZ-1:0] d;
        int             c;

        //       rst r0 d0    r1 d1    ack | rdy req a0 a1 data
        addVec(0, 1, 8'h11, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00);
        addVec(0, 1, 8'h11, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00);
        addVec(0, 1, 8'h11, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00);
        addVec(1, 1, 8'h11, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00);
        addVec(1, 1, 8'h11, 0, 8'h00, 0,  1, 1, 0, 0, 8'h11);
        addVec(1, 1, 8'h11, 0, 8'h00, 0,  1, 1, 0, 0, 8'h11);
        addVec(1, 1, 8'h11, 0, 8'h00, 1,  1, 0, 0, 0, 8'h11);
        addVec(1, 1, 8'h11, 0, 8'h00, 1,  1, 0, 0, 0, 8'h11);
        addVec(1, 1, 8'h11, 0, 8'h00, 0,  1, 0, 1, 0, 8'h11);
        addVec(1, 1, 8'h11, 0, 8'h00, 0,  1, 0, 1, 0, 8'h11);
        addVec(1, 0, 8'h11, 0, 8'h00, 0,  1, 0, 0, 0, 8'h11);
        addVec(1, 0, 8'h11, 1, 8'hAA, 0,  1, 0, 0, 0, 8'h11);
        addVec(1, 1, 8'h22, 1, 8'hAA, 0,  1, 1, 0, 0, 8'h22);
        addVec(1, 1, 8'h22, 1, 8'hAA, 1,  1, 0, 0, 0, 8'h22);
        addVec(1, 1, 8'h22, 1, 8'hAA, 0,  1, 0, 1, 0, 8'h22);
        addVec(1, 0, 8'h22, 1, 8'hAA, 0,  1, 0, 0, 0, 8'h22);
        addVec(1, 1, 8'h33, 1, 8'hAA, 0,  1, 1, 0, 0, 8'h33);
        addVec(1, 1, 8'h33, 1, 8'hAA, 1,  1, 0, 0, 0, 8'h33);
        addVec(1, 1, 8'h33, 1, 8'hAA, 0,  1, 0, 1, 0, 8'h33);
        addVec(1, 0, 8'h33, 1, 8'hAA, 0,  1, 0, 0, 0, 8'h33);
        addVec(1, 1, 8'h44, 1, 8'hAA, 0,  1, 1, 0, 0, 8'hAA);
        addVec(1, 1, 8'h44, 1, 8'hAA, 1,  1, 0, 0, 0, 8'hAA);
        addVec(1, 1, 8'h44, 1, 8'hAA, 0,  1, 0, 0, 1, 8'hAA);
        addVec(1, 1, 8'h44, 0, 8'hAA, 0,  1, 0, 0, 0, 8'hAA);
        addVec(0, 1, 8'h44, 0, 8'hAA, 0,  0, 0, 0, 0, 8'h00);

        @(negedge gch_clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge gch_clk);
            #1;
            checkOutput($sformatf("vec%0d", i), 32'(outVec()), 32'(vecs[i].exp_out));
            @(negedge gch_clk);
        end

        // Hand the links over to the behavioural source and sink threads.
        tab_mode = 1'b0;
        sink_en  = 1'b1;
        mon_en   = 1'b1;

        // Back-pressure: pakin never acks, so the request and data must stay frozen.
        doReset(2);
        repeat (2) @(negedge gch_clk);
        sink_stall = 1'b1;
        q0.push_back(8'h5A);
        c = 0;
        while (!snd0_req && c < 20) begin
            @(negedge gch_clk);
            c++;
        end
        checkOutput("bp_req_up", 32'(snd0_req), 32'd1);
        for (int i = 0; i < 50; i++) begin
            @(negedge gch_clk);
            checkOutput($sformatf("bp_hold%0d", i),
                        32'({snd0_req, rcv0_ack, rcv1_ack, snd0_data}), 32'({3'b100, 8'h5A}));
        end
        sink_stall = 1'b0;
        waitRx(1, 100, "bp_released");
        if (rx_q.size() >= 1) checkOutput("bp_data", 32'(rx_q[0]), 32'h5A);
        waitSrcIdle(0);

        // Abort after two packets of a message; the next message must again be three packets long.
        doReset(2);
        rx_q.delete();
        repeat (2) @(negedge gch_clk);
        q0.push_back(8'h01);
        q0.push_back(8'h02);
        waitRx(2, 200, "abort_first_two");
        waitSrcIdle(0);
        repeat (2) @(negedge gch_clk);
        doReset(2);
        repeat (2) @(negedge gch_clk);
        @(posedge gch_clk);
        q0.push_back(8'h0A); q0.push_back(8'h0B); q0.push_back(8'h0C);
        q1.push_back(8'hB1);
        @(negedge gch_clk);
        waitRx(6, 500, "abort_restart");
        exp_q = '{8'h01, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'hB1};
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            checkOutput($sformatf("abort_pkt%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        waitSrcIdle(0);
        waitSrcIdle(1);

        // Randomized run with both sources backlogged: whole messages strictly alternate, src0 first.
        doReset(2);
        rx_q.delete();
        exp_q.delete();
        sink_dly_max = 3;
        src_gap_max  = 3;
        repeat (2) @(negedge gch_clk);
        @(posedge gch_clk);
        for (int m = 0; m < 4; m++) begin
            for (int s = 0; s < 2; s++) begin
                for (int p = 0; p < TOT_PKS; p++) begin
                    d = {s[0], 7'($urandom_range(127, 0))};
                    if (s == 0) q0.push_back(d);
                    else        q1.push_back(d);
                    exp_q.push_back(d);
                end
            end
        end
        @(negedge gch_clk);
        waitRx(exp_q.size(), 3000, "rr_count");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            checkOutput($sformatf("rr_pkt%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        waitSrcIdle(0);
        waitSrcIdle(1);

        checkOutput("protocol_violations", 32'(mon_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
